dft_bin_serializer: RTL and testbench
=====================================

// Module: dft_bin_serializer
// PURPOSE
//  Output-side reader for the 32-point DFT result bank. It takes one 32-bin
//  frame in parallel from the DFT file-register outputs, then streams the bins
//  one per accepted beat in natural order 0..31. A valid/ready handshake paces
//  the stream. An optional stage converts each bin from sign-magnitude to
//  two's complement. Downstream consumers (UART/AXI-stream bridges) see a
//  single narrow port instead of 32 wide buses.
// PARAMETERS
//  fix_bit   7   fractional bits of each Q-format part (pass-through, documents format)
//  bits      16  width of one real/imag part; one bin = 2*bits
//  TWOS_OUT  1   1: emit two's complement parts; 0: emit sign-magnitude unchanged
// PORTS
//  clk         in   1          single clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  frame_in    in   32*2*bits  bin k at [k*2*bits +: 2*bits]; bin = {imag, real}, each sign-magnitude
//  frame_valid in   1          frame_in holds a complete frame this cycle
//  frame_ready out  1          block will capture frame_in when frame_valid is high
//  bin_data    out  2*bits     current bin {imag, real}
//  bin_index   out  5          index k of bin_data
//  bin_valid   out  1          bin_data/bin_index/bin_last are valid
//  bin_ready   in   1          consumer accepts the beat
//  bin_last    out  1          high with bin_valid while bin_index==31
//  drop_count  out  8          frames offered (frame_valid & !frame_ready), saturates at 255
// BEHAVIOUR
//  Reset (reset==0): state=IDLE, frame_ready=1, bin_valid=0, bin_last=0,
//   bin_index=0, bin_data=0, drop_count=0, capture buffer cleared.
//  FSM states:
//   IDLE   - frame_ready=1, bin_valid=0. frame_valid=1 -> capture all 32 bins
//            into buffer, idx<=0, go to STREAM.
//   STREAM - bin_valid=1, bin_data=conv(buf[idx]), bin_index=idx.
//            Beat accepted when bin_valid & bin_ready: idx<=idx+1.
//            Beat accepted with idx==31 -> IDLE (idx wraps to 0).
//  frame_ready is registered. It is high only in IDLE and does not look ahead
//   (no same-cycle capture on the last beat). After bin 31 is accepted, there
//   is a 1-cycle gap, then a new frame can be taken.
//  Latency: frame captured at edge N -> bin 0 valid after edge N. Full frame
//   with bin_ready held high takes 32 cycles, plus 1 IDLE cycle between frames.
//  Holding: while bin_valid=1 and bin_ready=0, bin_data/bin_index/bin_last stay
//   stable. bin_valid never drops before acceptance.
//  The buffer is written only on capture. frame_in changes during STREAM are
//   ignored.
//  drop_count increments when frame_valid=1 and frame_ready=0. It saturates
//   at 8'hFF and is cleared only by reset.
//  conv(), TWOS_OUT=1, applied per part:
//   - sign=0 -> value unchanged.
//   - sign=1, mag!=0 -> -mag in bits-bit two's complement.
//   - sign=1, mag==0 (negative zero) -> 0.
//   - No overflow is possible: magnitude is at most 2^(bits-1)-1.
//  conv() is a purely combinational function of the buffered bin. bin_data
//   has no added pipeline stage.
//  Reset asserted mid-frame: the stream aborts immediately and all outputs
//   return to their reset values. The partial frame is not resumed.
// TESTING
//  1 Reset, hold bin_ready=1, offer a frame with bin k = {16'h0000, k}.
//    -> 32 beats, bin_index 0..31, real=k, bin_last only on beat 31, then
//    frame_ready=1 one cycle later.
//  2 Negative parts, TWOS_OUT=1: a bin {16'h8018, 16'h807D} -> bin_data
//    {16'hFFE8, 16'hFF83}. A bin {16'h8000, 16'h0080} (negative zero imag)
//    -> {16'h0000, 16'h0080}. With TWOS_OUT=0, data passes through unchanged.
//  3 Backpressure: drop bin_ready for 3 cycles at bin_index=5.
//    -> bin_data and bin_index stay at 5, no skipped or duplicated bin,
//    frame still ends at 31.
//  4 Hold frame_valid=1 continuously for 2 back-to-back frames (bin_ready=1).
//    -> drop_count=32 per streamed frame (1 capture cycle, 32 beats not
//    ready). Force 300 drops -> drop_count stays at 255.
//  5 Assert reset at bin_index=12, release, offer a new frame.
//    -> outputs at reset values during reset, and the new frame streams
//    from bin 0.
//  6 Change frame_in while streaming.
//    -> the streamed values match the frame captured at capture time.

Source files
------------

// File: rtl/dft_bin_serializer.sv
// Streams one captured 32-bin DFT frame out as {imag, real} beats under valid/ready,
// optionally converting each sign-magnitude part to two's complement.
module dft_bin_serializer #(
    parameter int fix_bit  = 7,
    parameter int bits     = 16,
    parameter bit TWOS_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [64*bits-1:0]  frame_in,
    input  logic                frame_valid,
    output logic                frame_ready,
    output logic [2*bits-1:0]   bin_data,
    output logic [4:0]          bin_index,
    output logic                bin_valid,
    input  logic                bin_ready,
    output logic                bin_last,
    output logic [7:0]          drop_count
);
    localparam int bin_w  = 2 * bits;
    localparam int n_bins = 32;

    if (fix_bit >= bits) begin : g_bad_format
        $error("fix_bit must be smaller than bits");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [bin_w-1:0] bin_buf [n_bins];
    logic             frame_ready_q;
    logic [7:0]       drop_q;
    logic             capture;

    // Negative zero falls out naturally: ~0 + 1 wraps to 0 in bits width.
    function automatic logic [bits-1:0] conv_part(input logic [bits-1:0] p);
        logic [bits-1:0] mag;
        mag = {1'b0, p[bits-2:0]};
        if (!TWOS_OUT || !p[bits-1])
            return p;
        return (~mag) + 1'b1;
    endfunction

    assign capture = frame_ready_q && frame_valid;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    state_d = STREAM;
                    idx_d   = 5'd0;
                end
            end
            STREAM: begin
                if (bin_ready) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            idx_q         <= 5'd0;
            frame_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_ready_q <= (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < n_bins; k++)
                bin_buf[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < n_bins; k++)
                bin_buf[k] <= frame_in[k*bin_w +: bin_w];
        end
    end

    // Frames offered while busy are counted, saturating so the count never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_q <= 8'd0;
        else if (frame_valid && !frame_ready_q && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign frame_ready = frame_ready_q;
    assign bin_valid   = (state_q == STREAM);
    assign bin_index   = idx_q;
    assign bin_last    = (state_q == STREAM) && (idx_q == 5'd31);
    assign drop_count  = drop_q;
    assign bin_data    = (state_q == STREAM)
                       ? {conv_part(bin_buf[idx_q][bin_w-1:bits]), conv_part(bin_buf[idx_q][bits-1:0])}
                       : '0;
endmodule

// File: tb/tb_dft_bin_serializer.sv
// Scoreboard bench for dft_bin_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares each accepted beat on both conversion variants.
module tb_dft_bin_serializer;
    logic          clk;
    logic          reset;
    logic [1023:0] frame_in;
    logic          frame_valid;
    logic          bin_ready;
    logic          frame_ready, bin_valid, bin_last;
    logic [31:0]   bin_data;
    logic [4:0]    bin_index;
    logic [7:0]    drop_count;
    logic          raw_frame_ready, raw_bin_valid, raw_bin_last;
    logic [31:0]   raw_bin_data;
    logic [4:0]    raw_bin_index;
    logic [7:0]    raw_drop_count;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] conv;
        logic [31:0] raw;
        logic        last;
    } exp_t;

    exp_t          sb[$];
    logic [1023:0] cur_frame;
    logic [31:0]   cur_exp [32];
    int            checks = 0;
    int            errors = 0;

    dft_bin_serializer #(.fix_bit(7), .bits(16), .TWOS_OUT(1'b1)) dut (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .bin_data(bin_data), .bin_index(bin_index),
        .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_last(bin_last),
        .drop_count(drop_count)
    );

    dft_bin_serializer #(.fix_bit(7), .bits(16), .TWOS_OUT(1'b0)) dut_raw (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
        .frame_ready(raw_frame_ready), .bin_data(raw_bin_data), .bin_index(raw_bin_index),
        .bin_valid(raw_bin_valid), .bin_ready(bin_ready), .bin_last(raw_bin_last),
        .drop_count(raw_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_conv(input logic [15:0] p);
        int m;
        if (!p[15])
            return p;
        m = int'(p[14:0]);
        if (m == 0)
            return 16'h0000;
        return 16'(65536 - m);
    endfunction

    task automatic set_frame(input logic [1023:0] f);
        cur_frame = f;
        for (int k = 0; k < 32; k++)
            cur_exp[k] = {model_conv(f[k*32+16 +: 16]), model_conv(f[k*32 +: 16])};
    endtask

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < 32; k++) begin
            e.idx  = 5'(k);
            e.conv = cur_exp[k];
            e.raw  = cur_frame[k*32 +: 32];
            e.last = (k == 31);
            sb.push_back(e);
        end
    endtask

    task automatic apply_stimulus();
        int t = 0;
        while (!frame_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("frame_ready_before_capture", 32'(frame_ready), 32'd1);
        frame_in    = cur_frame;
        frame_valid = 1'b1;
        push_frame();
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("drain_queue_empty", 32'(sb.size()), 32'd0);
        check_output("frame_ready_after_last", 32'(frame_ready), 32'd1);
        check_output("bin_valid_after_last", 32'(bin_valid), 32'd0);
    endtask

    task automatic wait_index(input logic [4:0] target);
        int t = 0;
        while (!(bin_valid && bin_index == target) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check_output("reach_index", 32'(bin_index), 32'(target));
    endtask

    task automatic check_reset_values();
        check_output("rst_frame_ready", 32'(frame_ready), 32'd1);
        check_output("rst_bin_valid", 32'(bin_valid), 32'd0);
        check_output("rst_bin_last", 32'(bin_last), 32'd0);
        check_output("rst_bin_index", 32'(bin_index), 32'd0);
        check_output("rst_bin_data", bin_data, 32'd0);
        check_output("rst_drop_count", 32'(drop_count), 32'd0);
    endtask

    // Monitor: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (bin_valid && bin_ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_beat", 32'(bin_index), 32'hFFFF_FFFF);
            end else begin
                automatic exp_t e = sb.pop_front();
                check_output("beat_index", 32'(bin_index), 32'(e.idx));
                check_output("beat_data", bin_data, e.conv);
                check_output("beat_last", 32'(bin_last), 32'(e.last));
                check_output("raw_beat_valid", 32'(raw_bin_valid), 32'd1);
                check_output("raw_beat_index", 32'(raw_bin_index), 32'(e.idx));
                check_output("raw_beat_data", raw_bin_data, e.raw);
                check_output("raw_beat_last", 32'(raw_bin_last), 32'(e.last));
            end
        end
    end

    initial begin
        logic [1023:0] f;

        reset       = 1'b0;
        frame_valid = 1'b0;
        bin_ready   = 1'b1;
        frame_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] test 1: ascending real parts");
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'h0000, 16'(k)};
        set_frame(f);
        apply_stimulus();
        wait_drain();

        $display("[TB] test 2: sign-magnitude conversion");
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'h8000 | 16'(k << 4), 16'(k)};
        f[0*32 +: 32] = {16'h8018, 16'h807D};
        f[1*32 +: 32] = {16'h8000, 16'h0080};
        f[2*32 +: 32] = {16'hFFFF, 16'h7FFF};
        f[3*32 +: 32] = {16'h0000, 16'h8000};
        set_frame(f);
        cur_exp[0] = {16'hFFE8, 16'hFF83};
        cur_exp[1] = {16'h0000, 16'h0080};
        cur_exp[2] = {16'h8001, 16'h7FFF};
        cur_exp[3] = {16'h0000, 16'h0000};
        cur_exp[4] = {16'hFFC0, 16'h0004};
        apply_stimulus();
        wait_drain();

        $display("[TB] test 3: backpressure at bin 5");
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'h8000 | 16'(k), 16'(k)};
        set_frame(f);
        cur_exp[5] = {16'hFFFB, 16'h0005};
        apply_stimulus();
        wait_index(5'd5);
        bin_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_output("hold_index", 32'(bin_index), 32'd5);
            check_output("hold_data", bin_data, 32'hFFFB_0005);
            check_output("hold_valid", 32'(bin_valid), 32'd1);
        end
        bin_ready = 1'b1;
        wait_drain();

        $display("[TB] test 4: continuous frame_valid, drop counting");
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'(k * 3), 16'h8000 | 16'(k + 1)};
        set_frame(f);
        frame_in = cur_frame;
        check_output("t4_ready_at_start", 32'(frame_ready), 32'd1);
        frame_valid = 1'b1;
        push_frame();
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c == 66)
                check_output("drops_two_frames", 32'(drop_count), 32'd64);
            if (frame_ready) begin
                if (c < 330) begin
                    push_frame();
                end else begin
                    frame_valid = 1'b0;
                    break;
                end
            end
        end
        frame_valid = 1'b0;
        wait_drain();
        check_output("drops_saturated", 32'(drop_count), 32'd255);
        check_output("raw_drops_saturated", 32'(raw_drop_count), 32'd255);

        $display("[TB] test 5: reset mid-frame");
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'h0000, 16'(k)};
        set_frame(f);
        apply_stimulus();
        wait_index(5'd12);
        reset = 1'b0;
        sb.delete();
        #1;
        check_reset_values();
        @(posedge clk); #1;
        check_reset_values();
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'(k + 7), 16'h8000 | 16'(k * 5)};
        set_frame(f);
        apply_stimulus();
        wait_drain();

        $display("[TB] test 6: frame_in changes while streaming");
        for (int k = 0; k < 32; k++)
            f[k*32 +: 32] = {16'h8000 | 16'(k + 2), 16'(k * 9)};
        set_frame(f);
        apply_stimulus();
        frame_in = ~cur_frame;
        repeat (4) @(posedge clk);
        #1;
        frame_in = '0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
